bsg_idiv_iterative_sequencer: RTL and testbench

Front-end and back-end wrapper stage for the iterative integer divider. It accepts tagged DIV/DIVU/REM/REMU requests into a small FIFO and issues them one at a time to the divider over valid/ready. It consumes the divider's quotient/remainder over valid/yumi, selects the requested result, and presents it with its tag. It caches the last completed operand pair so a DIV followed by a REM (or the reverse) on the same operands completes without a second divide.

---
 rtl/bsg_idiv_iterative_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_bsg_idiv_iterative_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_idiv_iterative_sequencer.sv
// Request sequencer wrapped around the iterative integer divider.
// Buffers tagged DIV/DIVU/REM/REMU requests in a small FIFO, issues misses to the
// divider one at a time, and captures the selected result with its tag into a
// single-entry output register. The last completed operand pair (with signedness)
// is cached with both quotient and remainder, so a DIV/REM pair on the same
// operands needs only one divide.
//
// Ports:
//   clk_i, reset_i                        clock, synchronous active-high reset
//   v_i, ready_and_o                      request handshake (ready = FIFO not full)
//   dividend_i, divisor_i, op_i, tag_i    request payload (op: bit0 unsigned, bit1 rem)
//   div_v_o, div_ready_and_i              issue handshake to the divider
//   div_dividend_o, div_divisor_o         FIFO head operands
//   div_signed_o                          FIFO head signedness
//   div_v_i, div_yumi_o                   divider result handshake
//   div_quotient_i, div_remainder_i       divider results
//   v_o, result_o, tag_o, yumi_i          selected result output handshake
module bsg_idiv_iterative_sequencer #(
    parameter int unsigned width_p     = 32,
    parameter int unsigned tag_width_p = 4,
    parameter int unsigned els_p       = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic                   v_i,
    output logic                   ready_and_o,
    input  logic [width_p-1:0]     dividend_i,
    input  logic [width_p-1:0]     divisor_i,
    input  logic [1:0]             op_i,
    input  logic [tag_width_p-1:0] tag_i,

    output logic                   div_v_o,
    input  logic                   div_ready_and_i,
    output logic [width_p-1:0]     div_dividend_o,
    output logic [width_p-1:0]     div_divisor_o,
    output logic                   div_signed_o,

    input  logic                   div_v_i,
    input  logic [width_p-1:0]     div_quotient_i,
    input  logic [width_p-1:0]     div_remainder_i,
    output logic                   div_yumi_o,

    output logic                   v_o,
    output logic [width_p-1:0]     result_o,
    output logic [tag_width_p-1:0] tag_o,
    input  logic                   yumi_i
);

    localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w = $clog2(els_p + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Request FIFO storage and pointers
    logic [width_p-1:0]     fifo_a   [els_p];
    logic [width_p-1:0]     fifo_b   [els_p];
    logic [1:0]             fifo_op  [els_p];
    logic [tag_width_p-1:0] fifo_tag [els_p];
    logic [ptr_w-1:0]       rd_ptr, wr_ptr;
    logic [cnt_w-1:0]       count;

    state_t state, state_n;

    // In-flight request (operands kept for the cache write on completion)
    logic [width_p-1:0]     inf_a, inf_b;
    logic [1:0]             inf_op;
    logic [tag_width_p-1:0] inf_tag;

    // Last completed divide
    logic                   cache_valid;
    logic [width_p-1:0]     cache_a, cache_b, cache_q, cache_r;
    logic                   cache_signed;

    logic                   enq, deq, issue, out_load, cache_wr;
    logic                   head_v, hit, out_free;
    logic [width_p-1:0]     head_a, head_b;
    logic [1:0]             head_op;
    logic [tag_width_p-1:0] head_tag;
    logic [width_p-1:0]     out_val;
    logic [tag_width_p-1:0] out_tag;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign ready_and_o = (count != cnt_w'(els_p));
    assign enq         = v_i & ready_and_o;
    assign head_v      = (count != '0);
    assign head_a      = fifo_a[rd_ptr];
    assign head_b      = fifo_b[rd_ptr];
    assign head_op     = fifo_op[rd_ptr];
    assign head_tag    = fifo_tag[rd_ptr];
    assign out_free    = ~v_o | yumi_i;

    // Op[1] is not part of the match: both results are cached together
    assign hit = cache_valid & (head_a == cache_a) & (head_b == cache_b)
               & (~head_op[0] == cache_signed);

    assign div_dividend_o = head_a;
    assign div_divisor_o  = head_b;
    assign div_signed_o   = ~head_op[0];

    // FIFO payload storage (no reset needed, guarded by count)
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_a[wr_ptr]   <= dividend_i;
            fifo_b[wr_ptr]   <= divisor_i;
            fifo_op[wr_ptr]  <= op_i;
            fifo_tag[wr_ptr] <= tag_i;
        end
    end

    // FIFO control
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + cnt_w'(enq) - cnt_w'(deq);
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_n;
    end

    // Next state, handshakes and output-load selection
    always_comb begin
        state_n    = state;
        div_v_o    = 1'b0;
        div_yumi_o = 1'b0;
        deq        = 1'b0;
        issue      = 1'b0;
        out_load   = 1'b0;
        out_val    = '0;
        out_tag    = '0;
        cache_wr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (head_v) begin
                    if (!hit) begin
                        div_v_o = 1'b1;
                        if (div_ready_and_i) begin
                            deq     = 1'b1;
                            issue   = 1'b1;
                            state_n = ST_WAIT;
                        end
                    end else if (out_free) begin
                        deq      = 1'b1;
                        out_load = 1'b1;
                        out_val  = head_op[1] ? cache_r : cache_q;
                        out_tag  = head_tag;
                    end
                end
            end
            ST_WAIT: begin
                if (div_v_i && out_free) begin
                    div_yumi_o = 1'b1;
                    out_load   = 1'b1;
                    out_val    = inf_op[1] ? div_remainder_i : div_quotient_i;
                    out_tag    = inf_tag;
                    cache_wr   = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // In-flight request capture at issue
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inf_a   <= '0;
            inf_b   <= '0;
            inf_op  <= '0;
            inf_tag <= '0;
        end else if (issue) begin
            inf_a   <= head_a;
            inf_b   <= head_b;
            inf_op  <= head_op;
            inf_tag <= head_tag;
        end
    end

    // Result cache
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_signed <= 1'b0;
            cache_q      <= '0;
            cache_r      <= '0;
        end else if (cache_wr) begin
            cache_valid  <= 1'b1;
            cache_a      <= inf_a;
            cache_b      <= inf_b;
            cache_signed <= ~inf_op[0];
            cache_q      <= div_quotient_i;
            cache_r      <= div_remainder_i;
        end
    end

    // Single-entry output register; load and consume may coincide
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o      <= 1'b0;
            result_o <= '0;
            tag_o    <= '0;
        end else if (out_load) begin
            v_o      <= 1'b1;
            result_o <= out_val;
            tag_o    <= out_tag;
        end else if (yumi_i) begin
            v_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bsg_idiv_iterative_sequencer.sv
// Self-checking bench for bsg_idiv_iterative_sequencer: directed scenarios plus a
// randomized run, with a bench-side divider responder and an in-order result model.
module tb_bsg_idiv_iterative_sequencer;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v_i, ready_and_o;
    logic [W-1:0]  dividend_i, divisor_i;
    logic [1:0]    op_i;
    logic [TW-1:0] tag_i;
    logic          div_v_o, div_ready_and_i;
    logic [W-1:0]  div_dividend_o, div_divisor_o;
    logic          div_signed_o;
    logic          div_v_i;
    logic [W-1:0]  div_quotient_i, div_remainder_i;
    logic          div_yumi_o;
    logic          v_o;
    logic [W-1:0]  result_o;
    logic [TW-1:0] tag_o;
    logic          yumi_i;

    bsg_idiv_iterative_sequencer #(.width_p(W), .tag_width_p(TW), .els_p(2)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(v_i), .ready_and_o(ready_and_o),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .op_i(op_i), .tag_i(tag_i),
        .div_v_o(div_v_o), .div_ready_and_i(div_ready_and_i),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_signed_o(div_signed_o),
        .div_v_i(div_v_i), .div_quotient_i(div_quotient_i),
        .div_remainder_i(div_remainder_i), .div_yumi_o(div_yumi_o),
        .v_o(v_o), .result_o(result_o), .tag_o(tag_o), .yumi_i(yumi_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [1:0] op; logic [TW-1:0] tag; } req_t;
    typedef struct { logic [W-1:0] res; logic [TW-1:0] tag; } out_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic sgn; } iss_t;

    req_t stim[$];
    out_t exp_out[$];
    out_t seen[$];
    iss_t exp_issue[$];

    int vectors = 0;
    int errors  = 0;
    int issues  = 0;

    // Bench-side divider
    logic         dbusy = 1'b0;
    int           dcnt  = 0;
    logic [W-1:0] dq = '0, dr = '0;
    int           lat_min = 1, lat_max = 3;

    // Model cache: operands of the most recent divide, in request order
    logic         mc_v = 1'b0;
    logic [W-1:0] mc_a = '0, mc_b = '0;
    logic         mc_s = 1'b0;

    int  v_prob = 100, rdy_prob = 100, yumi_prob = 100;
    logic yumi_en = 1'b1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Divider arithmetic (RISC-V M semantics): returns {quotient, remainder}
    function automatic logic [2*W-1:0] divfn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        logic [W-1:0] q, r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic model_enq(input req_t r);
        logic         sgn;
        logic [2*W-1:0] qr;
        out_t         o;
        iss_t         is;
        sgn = ~r.op[0];
        qr  = divfn(r.a, r.b, sgn);
        if (!(mc_v && mc_a == r.a && mc_b == r.b && mc_s == sgn)) begin
            is.a = r.a; is.b = r.b; is.sgn = sgn;
            exp_issue.push_back(is);
            mc_v = 1'b1; mc_a = r.a; mc_b = r.b; mc_s = sgn;
        end
        o.res = r.op[1] ? qr[W-1:0] : qr[2*W-1:W];
        o.tag = r.tag;
        exp_out.push_back(o);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op, input logic [TW-1:0] tag);
        req_t r;
        r.a = a; r.b = b; r.op = op; r.tag = tag;
        stim.push_back(r);
    endtask

    // One clock: drive at negedge, evaluate handshakes once inputs settle
    task automatic cycle();
        logic [2*W-1:0] qr;
        @(negedge clk);
        if (stim.size() > 0 && $urandom_range(99) < v_prob) begin
            v_i = 1'b1;
            dividend_i = stim[0].a; divisor_i = stim[0].b; op_i = stim[0].op; tag_i = stim[0].tag;
        end else begin
            v_i = 1'b0;
            dividend_i = $urandom; divisor_i = $urandom; op_i = 2'($urandom); tag_i = TW'($urandom);
        end
        div_ready_and_i = !dbusy && ($urandom_range(99) < rdy_prob);
        div_v_i         = dbusy && dcnt == 0;
        div_quotient_i  = dbusy ? dq : $urandom;
        div_remainder_i = dbusy ? dr : $urandom;
        yumi_i          = yumi_en && ($urandom_range(99) < yumi_prob);
        #2;
        if (v_o) begin
            if (exp_out.size() == 0) chk("unexpected_v_o", 32'(v_o), 32'd0);
            else begin
                chk("result", result_o, exp_out[0].res);
                chk("tag", 32'(tag_o), 32'(exp_out[0].tag));
            end
        end
        chk("div_yumi", 32'(div_yumi_o), 32'(div_v_i & (~v_o | yumi_i)));
        if (dbusy) chk("div_v_while_busy", 32'(div_v_o), 32'd0);
        if (v_o && yumi_i && exp_out.size() > 0) begin
            seen.push_back(exp_out[0]);
            seen[seen.size()-1].res = result_o;
            seen[seen.size()-1].tag = tag_o;
            void'(exp_out.pop_front());
        end
        if (v_i && ready_and_o) model_enq(stim.pop_front());
        if (div_v_o && div_ready_and_i) begin
            if (exp_issue.size() == 0) chk("unexpected_issue", 32'(div_v_o), 32'd0);
            else begin
                chk("issue_a", div_dividend_o, exp_issue[0].a);
                chk("issue_b", div_divisor_o, exp_issue[0].b);
                chk("issue_signed", 32'(div_signed_o), 32'(exp_issue[0].sgn));
                void'(exp_issue.pop_front());
            end
            issues++;
            qr    = divfn(div_dividend_o, div_divisor_o, div_signed_o);
            dq    = qr[2*W-1:W];
            dr    = qr[W-1:0];
            dbusy = 1'b1;
            dcnt  = $urandom_range(lat_max, lat_min);
        end else if (dbusy && div_v_i && div_yumi_o) begin
            dbusy = 1'b0;
        end else if (dbusy && dcnt > 0) begin
            dcnt--;
        end
    endtask

    task automatic drain(input int maxc);
        bit done = 0;
        for (int i = 0; i < maxc; i++) begin
            if (stim.size() == 0 && exp_out.size() == 0 && exp_issue.size() == 0 && !dbusy) begin
                done = 1;
                break;
            end
            cycle();
        end
        if (!done) chk("drain_timeout", 32'(exp_out.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1; v_i = 1'b0; div_v_i = 1'b0; yumi_i = 1'b0; div_ready_and_i = 1'b0;
        stim.delete(); exp_out.delete(); exp_issue.delete(); seen.delete();
        dbusy = 1'b0; dcnt = 0; mc_v = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        #2;
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_ready", 32'(ready_and_o), 32'd1);
        chk("rst_div_v_o", 32'(div_v_o), 32'd0);
    endtask

    initial begin
        logic [2*W-1:0] qr;
        int base;
        logic [W-1:0] pool_a [6];
        logic [W-1:0] pool_b [6];
        reset_i = 1'b1; v_i = 1'b0; dividend_i = '0; divisor_i = '0; op_i = '0; tag_i = '0;
        div_ready_and_i = 1'b0; div_v_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
        yumi_i = 1'b0;
        repeat (2) @(negedge clk);

        // Pin the arithmetic model with hand-computed values
        qr = divfn(32'hFFFFFFF9, 32'd2, 1'b1);
        chk("pin_q_neg7_2", qr[2*W-1:W], 32'hFFFFFFFD);
        chk("pin_r_neg7_2", qr[W-1:0], 32'hFFFFFFFF);
        qr = divfn(32'd5, 32'd0, 1'b0);
        chk("pin_q_div0", qr[2*W-1:W], 32'hFFFFFFFF);
        chk("pin_r_div0", qr[W-1:0], 32'd5);

        // DIV -7/2
        do_reset();
        base = issues;
        send(32'hFFFFFFF9, 32'd2, 2'b00, 4'd3);
        drain(100);
        chk("t1_issues", 32'(issues - base), 32'd1);
        chk("t1_n", 32'(seen.size()), 32'd1);
        if (seen.size() >= 1) begin
            chk("t1_res", seen[0].res, 32'hFFFFFFFD);
            chk("t1_tag", 32'(seen[0].tag), 32'd3);
        end

        // DIV then REM on the same operands: one divide
        do_reset();
        base = issues;
        send(32'd100, 32'd7, 2'b00, 4'd1);
        send(32'd100, 32'd7, 2'b10, 4'd2);
        drain(100);
        chk("t2_issues", 32'(issues - base), 32'd1);
        chk("t2_n", 32'(seen.size()), 32'd2);
        if (seen.size() >= 2) begin
            chk("t2_res0", seen[0].res, 32'd14);
            chk("t2_tag0", 32'(seen[0].tag), 32'd1);
            chk("t2_res1", seen[1].res, 32'd2);
            chk("t2_tag1", 32'(seen[1].tag), 32'd2);
        end

        // Signedness mismatch: two divides
        do_reset();
        base = issues;
        send(32'hFFFFFFFF, 32'd2, 2'b11, 4'd4);
        send(32'hFFFFFFFF, 32'd2, 2'b10, 4'd5);
        drain(100);
        chk("t3_issues", 32'(issues - base), 32'd2);
        chk("t3_n", 32'(seen.size()), 32'd2);
        if (seen.size() >= 2) begin
            chk("t3_res0", seen[0].res, 32'd1);
            chk("t3_res1", seen[1].res, 32'hFFFFFFFF);
        end

        // Output back-pressure fills the FIFO
        do_reset();
        lat_min = 2; lat_max = 2;
        yumi_en = 1'b0;
        send(32'd100, 32'd3, 2'b01, 4'd0);
        send(32'd200, 32'd7, 2'b01, 4'd1);
        send(32'd50,  32'd6, 2'b11, 4'd2);
        send(32'd81,  32'd9, 2'b00, 4'd3);
        repeat (40) cycle();
        chk("t4_ready_full", 32'(ready_and_o), 32'd0);
        chk("t4_v_o_held", 32'(v_o), 32'd1);
        chk("t4_div_v_pending", 32'(div_v_i), 32'd1);
        chk("t4_div_yumi_held", 32'(div_yumi_o), 32'd0);
        yumi_en = 1'b1;
        drain(200);
        chk("t4_n", 32'(seen.size()), 32'd4);
        if (seen.size() >= 4) begin
            chk("t4_res0", seen[0].res, 32'd33);
            chk("t4_res1", seen[1].res, 32'd28);
            chk("t4_res2", seen[2].res, 32'd2);
            chk("t4_res3", seen[3].res, 32'd9);
            for (int i = 0; i < 4; i++) chk("t4_tag_order", 32'(seen[i].tag), 32'(i));
        end

        // Reset while a divide is in flight
        do_reset();
        lat_min = 30; lat_max = 30;
        base = issues;
        send(32'd9, 32'd3, 2'b00, 4'd5);
        repeat (5) cycle();
        chk("t5_in_flight", 32'(issues - base), 32'd1);
        do_reset();
        lat_min = 1; lat_max = 3;
        base = issues;
        send(32'd9, 32'd3, 2'b10, 4'd6);
        drain(100);
        chk("t5_issues", 32'(issues - base), 32'd1);
        chk("t5_n", 32'(seen.size()), 32'd1);
        if (seen.size() >= 1) begin
            chk("t5_res", seen[0].res, 32'd0);
            chk("t5_tag", 32'(seen[0].tag), 32'd6);
        end

        // Divide by zero is cached like any result
        do_reset();
        base = issues;
        send(32'd5, 32'd0, 2'b01, 4'd7);
        send(32'd5, 32'd0, 2'b11, 4'd8);
        drain(100);
        chk("t6_issues", 32'(issues - base), 32'd1);
        chk("t6_n", 32'(seen.size()), 32'd2);
        if (seen.size() >= 2) begin
            chk("t6_res0", seen[0].res, 32'hFFFFFFFF);
            chk("t6_res1", seen[1].res, 32'd5);
        end

        // Randomized traffic with operand reuse to exercise hits
        pool_a[0] = 32'd100; pool_a[1] = 32'hFFFFFFFF; pool_a[2] = 32'h80000000;
        pool_a[3] = 32'd9;   pool_a[4] = 32'd5;        pool_a[5] = 32'hFFFFFFF9;
        pool_b[0] = 32'd0;   pool_b[1] = 32'd1;        pool_b[2] = 32'd2;
        pool_b[3] = 32'd7;   pool_b[4] = 32'hFFFFFFFF; pool_b[5] = 32'd3;
        v_prob = 60; rdy_prob = 60; yumi_prob = 50; lat_min = 1; lat_max = 5;
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] a, b;
            if (n > 0 && $urandom_range(1) == 0) begin
                a = stim.size() > 0 ? stim[stim.size()-1].a : pool_a[$urandom_range(5)];
                b = stim.size() > 0 ? stim[stim.size()-1].b : pool_b[$urandom_range(5)];
            end else begin
                a = ($urandom_range(3) == 0) ? $urandom : pool_a[$urandom_range(5)];
                b = ($urandom_range(3) == 0) ? $urandom : pool_b[$urandom_range(5)];
            end
            send(a, b, 2'($urandom), TW'(n));
            if (stim.size() > 4) repeat ($urandom_range(8, 1)) cycle();
        end
        drain(20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
